// File: rtl/dispatch_credit_ctrl.sv
// Dispatch-side credit gate: admits a whole rename bundle only when the active list,
// issue queue, load queue and store queue all hold enough free entries.
module dispatch_credit_ctrl #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int AL_SIZE        = 128,
    parameter int IQ_SIZE        = 32,
    parameter int LQ_SIZE        = 32,
    parameter int SQ_SIZE        = 32,
    parameter int FREE_W         = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic                            bundleValid_i,
    input  logic [DISPATCH_WIDTH-1:0]       laneValid_i,
    input  logic [DISPATCH_WIDTH-1:0]       isLoad_i,
    input  logic [DISPATCH_WIDTH-1:0]       isStore_i,
    input  logic [DISPATCH_WIDTH-1:0]       skipIQ_i,
    input  logic                            backEndStall_i,
    input  logic [FREE_W-1:0]               alFreed_i,
    input  logic [FREE_W-1:0]               iqFreed_i,
    input  logic [FREE_W-1:0]               lqFreed_i,
    input  logic [FREE_W-1:0]               sqFreed_i,
    output logic                            dispatch_o,
    output logic                            stall_o,
    output logic [$clog2(AL_SIZE+1)-1:0]    alCredit_o,
    output logic [$clog2(IQ_SIZE+1)-1:0]    iqCredit_o,
    output logic [$clog2(LQ_SIZE+1)-1:0]    lqCredit_o,
    output logic [$clog2(SQ_SIZE+1)-1:0]    sqCredit_o,
    output logic [31:0]                     stallCycles_o,
    output logic                            overflow_o
);

    localparam int AW = $clog2(AL_SIZE+1);
    localparam int IW = $clog2(IQ_SIZE+1);
    localparam int LW = $clog2(LQ_SIZE+1);
    localparam int SW = $clog2(SQ_SIZE+1);
    localparam int CW = $clog2(DISPATCH_WIDTH+1);

    logic [AW-1:0] al_credit_q, al_credit_d;
    logic [IW-1:0] iq_credit_q, iq_credit_d;
    logic [LW-1:0] lq_credit_q, lq_credit_d;
    logic [SW-1:0] sq_credit_q, sq_credit_d;
    logic [31:0]   stall_cnt_q;
    logic          overflow_q;

    logic [CW-1:0] n_al, n_iq, n_ld, n_st;
    logic [AW:0]   al_sum;
    logic [IW:0]   iq_sum;
    logic [LW:0]   lq_sum;
    logic [SW:0]   sq_sum;
    logic          fits;
    logic          ovf_any;

    always_comb begin
        n_al = '0;
        n_iq = '0;
        n_ld = '0;
        n_st = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            n_al = n_al + CW'(laneValid_i[i]);
            n_iq = n_iq + CW'(laneValid_i[i] & ~skipIQ_i[i]);
            n_ld = n_ld + CW'(laneValid_i[i] & isLoad_i[i]);
            n_st = n_st + CW'(laneValid_i[i] & isStore_i[i]);
        end
    end

    // Fit check looks at registered credits only; this cycle's returns are not bypassed.
    assign fits = (al_credit_q >= AW'(n_al)) & (iq_credit_q >= IW'(n_iq)) &
                  (lq_credit_q >= LW'(n_ld)) & (sq_credit_q >= SW'(n_st));

    assign dispatch_o = reset & bundleValid_i & fits & ~backEndStall_i & ~flush_i;
    assign stall_o    = reset & bundleValid_i & ~dispatch_o & ~flush_i;

    // Dispatch never takes more than is held, so the one-bit-wider sum cannot go negative.
    always_comb begin
        al_sum = {1'b0, al_credit_q} - (dispatch_o ? (AW+1)'(n_al) : '0) + (AW+1)'(alFreed_i);
        iq_sum = {1'b0, iq_credit_q} - (dispatch_o ? (IW+1)'(n_iq) : '0) + (IW+1)'(iqFreed_i);
        lq_sum = {1'b0, lq_credit_q} - (dispatch_o ? (LW+1)'(n_ld) : '0) + (LW+1)'(lqFreed_i);
        sq_sum = {1'b0, sq_credit_q} - (dispatch_o ? (SW+1)'(n_st) : '0) + (SW+1)'(sqFreed_i);

        al_credit_d = (al_sum > (AW+1)'(AL_SIZE)) ? AW'(AL_SIZE) : al_sum[AW-1:0];
        iq_credit_d = (iq_sum > (IW+1)'(IQ_SIZE)) ? IW'(IQ_SIZE) : iq_sum[IW-1:0];
        lq_credit_d = (lq_sum > (LW+1)'(LQ_SIZE)) ? LW'(LQ_SIZE) : lq_sum[LW-1:0];
        sq_credit_d = (sq_sum > (SW+1)'(SQ_SIZE)) ? SW'(SQ_SIZE) : sq_sum[SW-1:0];

        ovf_any = (al_sum > (AW+1)'(AL_SIZE)) | (iq_sum > (IW+1)'(IQ_SIZE)) |
                  (lq_sum > (LW+1)'(LQ_SIZE)) | (sq_sum > (SW+1)'(SQ_SIZE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_credit_q <= AW'(AL_SIZE);
            iq_credit_q <= IW'(IQ_SIZE);
            lq_credit_q <= LW'(LQ_SIZE);
            sq_credit_q <= SW'(SQ_SIZE);
            stall_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (flush_i) begin
                al_credit_q <= AW'(AL_SIZE);
                iq_credit_q <= IW'(IQ_SIZE);
                lq_credit_q <= LW'(LQ_SIZE);
                sq_credit_q <= SW'(SQ_SIZE);
            end else begin
                al_credit_q <= al_credit_d;
                iq_credit_q <= iq_credit_d;
                lq_credit_q <= lq_credit_d;
                sq_credit_q <= sq_credit_d;
                overflow_q  <= overflow_q | ovf_any;
            end
            if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign alCredit_o    = al_credit_q;
    assign iqCredit_o    = iq_credit_q;
    assign lqCredit_o    = lq_credit_q;
    assign sqCredit_o    = sq_credit_q;
    assign stallCycles_o = stall_cnt_q;
    assign overflow_o    = overflow_q;

endmodule
